fetch_issue_sequencer: RTL and testbench

//  Sequences the instruction pipeline: owns the program counter, drives instruction-memory reads,
//  and presents one instruction at a time to the decode/execute stage with a valid/ready handshake.

---
 rtl/fetch_issue_sequencer_if.sv | 38 +++
 rtl/fetch_issue_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_fetch_issue_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_issue_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_issue_sequencer_if
//  Description : Bus bundle between the fetch/issue sequencer, the
//                instruction store and the decode/execute stage.
//                  imem_rd_en / imem_addr  : read request toward the store
//                  imem_rdata              : read data, one cycle after request
//                  ex_valid / ex_ready     : issue handshake toward decode
//                  ex_instr / ex_pc        : issued instruction and its address
//                  jump_req / jump_target  : redirect from execute
//                master modport = sequencer side, slave modport = peer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_issue_sequencer_if #(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 32
);
    logic               imem_rd_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               ex_valid;
    logic               ex_ready;
    logic [INSTR_W-1:0] ex_instr;
    logic [PC_W-1:0]    ex_pc;
    logic               jump_req;
    logic [PC_W-1:0]    jump_target;

    modport master (
        output imem_rd_en, imem_addr, ex_valid, ex_instr, ex_pc,
        input  imem_rdata, ex_ready, jump_req, jump_target
    );

    modport slave (
        input  imem_rd_en, imem_addr, ex_valid, ex_instr, ex_pc,
        output imem_rdata, ex_ready, jump_req, jump_target
    );
endinterface
`default_nettype wire

// File: rtl/fetch_issue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_issue_sequencer
//  Description : Owns the program counter, issues instruction-memory reads
//                (1-cycle latency) and presents one instruction at a time to
//                decode with a valid/ready handshake. Handles jump redirects
//                and stops on the HALT opcode.
//  Ports       : clk          - clock, rising edge
//                reset        - asynchronous, active-high
//                start        - begin execution at PC 0 (IDLE/HALTED only)
//                busy         - high in FETCH/WAIT/ISSUE
//                done         - high in HALTED
//                stall_cycles - ISSUE cycles with ex_valid & !ex_ready
//                               (only with SEQ_STALL_CNT_EN defined)
//                bus          - fetch_issue_sequencer_if.master
//  Options     : SEQ_STALL_CNT_EN - adds the saturating stall counter
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_issue_sequencer #(
    parameter int                   PC_W     = 5,
    parameter int                   INSTR_W  = 32,
    parameter int                   OPC_HI   = 31,
    parameter int                   OPC_LO   = 15,
    parameter logic [OPC_HI-OPC_LO:0] HALT_OPC = 17'b10001111000000000
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic start,
    output logic      busy,
    output logic      done,
`ifdef SEQ_STALL_CNT_EN
    output logic [15:0] stall_cycles,
`endif
    fetch_issue_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        ISSUE  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               imem_rd_en_q, imem_rd_en_d;
    logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
    logic               ex_valid_q, ex_valid_d;
    logic [INSTR_W-1:0] ex_instr_q, ex_instr_d;
    logic [PC_W-1:0]    ex_pc_q, ex_pc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic handshake;
    logic is_halt;

    assign handshake = ex_valid_q & bus.ex_ready;
    assign is_halt   = (ex_instr_q[OPC_HI:OPC_LO] == HALT_OPC);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_addr_d = imem_addr_q;
        ex_instr_d  = ex_instr_q;
        ex_pc_d     = ex_pc_q;

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                // A redirect here re-enters FETCH; the read just issued
                // returns during that cycle and is never captured.
                if (bus.jump_req) begin
                    pc_d = bus.jump_target;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.jump_req) begin
                    state_d = FETCH;
                    pc_d    = bus.jump_target;
                end else begin
                    state_d    = ISSUE;
                    ex_instr_d = bus.imem_rdata;
                    ex_pc_d    = pc_q;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    pc_d = pc_q + PC_W'(1);
                    if (is_halt) begin
                        // HALT takes priority over a coincident jump.
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                        if (bus.jump_req) begin
                            pc_d = bus.jump_target;
                        end
                    end
                end else if (bus.jump_req) begin
                    state_d = FETCH;
                    pc_d    = bus.jump_target;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase

        // Outputs are derived from the next state so they are registered
        // alongside it and line up with the state they describe.
        imem_rd_en_d = (state_d == FETCH);
        if (state_d == FETCH) begin
            imem_addr_d = pc_d;
        end
        ex_valid_d = (state_d == ISSUE);
        busy_d     = (state_d == FETCH) || (state_d == WAIT) || (state_d == ISSUE);
        done_d     = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            imem_rd_en_q <= 1'b0;
            imem_addr_q  <= '0;
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= '0;
            ex_pc_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_rd_en_q <= imem_rd_en_d;
            imem_addr_q  <= imem_addr_d;
            ex_valid_q   <= ex_valid_d;
            ex_instr_q   <= ex_instr_d;
            ex_pc_q      <= ex_pc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (((state_q == IDLE) || (state_q == HALTED)) && start) begin
            stall_d = '0;
        end else if ((state_q == ISSUE) && ex_valid_q && !bus.ex_ready
                     && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign bus.imem_rd_en = imem_rd_en_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_instr   = ex_instr_q;
    assign bus.ex_pc      = ex_pc_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_issue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_issue_sequencer
//  Description : Directed self-checking bench for fetch_issue_sequencer with
//                a 1-cycle-latency instruction store model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_issue_sequencer;

    localparam logic [31:0] C_A    = 32'h8F00_8000; // opcode one LSB off HALT
    localparam logic [31:0] C_B    = 32'h0000_7FFF;
    localparam logic [31:0] C_C    = 32'hDEAD_BEEF;
    localparam logic [31:0] C_HALT = 32'h8F00_0000;
    localparam logic [31:0] C_D    = 32'h1234_5678;
    localparam logic [31:0] C_E    = 32'hCAFE_0001;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic [15:0] stall_cycles;
    logic [31:0] mem [32];
    logic [31:0] prog [4];

    int total;
    int bad;

    fetch_issue_sequencer_if #(.PC_W(5), .INSTR_W(32)) bus ();

    fetch_issue_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
`ifdef SEQ_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

`ifndef SEQ_STALL_CNT_EN
    assign stall_cycles = 16'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction store: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.imem_rd_en) begin
            bus.imem_rdata <= mem[bus.imem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0]  = C_A;
        mem[1]  = C_B;
        mem[2]  = C_C;
        mem[3]  = C_HALT;
        mem[17] = C_E;
        mem[31] = C_D;
        prog[0] = C_A;
        prog[1] = C_B;
        prog[2] = C_C;
        prog[3] = C_HALT;

        bus.imem_rdata  = 32'h0;
        bus.ex_ready    = 1'b0;
        bus.jump_req    = 1'b0;
        bus.jump_target = 5'h0;
        start = 1'b0;
        reset = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_rd_en",  32'(bus.imem_rd_en), 32'd0);
        chk("rst_addr",   32'(bus.imem_addr),  32'd0);
        chk("rst_valid",  32'(bus.ex_valid),   32'd0);
        chk("rst_instr",  bus.ex_instr,        32'd0);
        chk("rst_pc",     32'(bus.ex_pc),      32'd0);
        chk("rst_busy",   32'(busy),           32'd0);
        chk("rst_done",   32'(done),           32'd0);
        chk("rst_stall",  32'(stall_cycles),   32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy",  32'(busy),           32'd0);

        // 1: straight-line program, ready always high
        bus.ex_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_fetch_en",   32'(bus.imem_rd_en), 32'd1);
            chk("t1_fetch_addr", 32'(bus.imem_addr),  32'(i));
            chk("t1_busy",       32'(busy),           32'd1);
            tick();
            chk("t1_wait_en",    32'(bus.imem_rd_en), 32'd0);
            chk("t1_wait_valid", 32'(bus.ex_valid),   32'd0);
            tick();
            chk("t1_issue_valid", 32'(bus.ex_valid),  32'd1);
            chk("t1_issue_instr", bus.ex_instr,       prog[i]);
            chk("t1_issue_pc",    32'(bus.ex_pc),     32'(i));
            tick();
        end
        chk("t1_done",  32'(done),         32'd1);
        chk("t1_busy0", 32'(busy),         32'd0);
        chk("t1_valid0", 32'(bus.ex_valid), 32'd0);
        bus.jump_req    = 1'b1;
        bus.jump_target = 5'h07;
        tick();
        bus.jump_req = 1'b0;
        chk("halted_jump_done",  32'(done),           32'd1);
        chk("halted_jump_rd_en", 32'(bus.imem_rd_en), 32'd0);

        // 2: backpressure on B for 5 cycles
        bus.ex_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_restart_addr", 32'(bus.imem_addr),  32'd0);
        chk("t2_restart_en",   32'(bus.imem_rd_en), 32'd1);
        chk("t2_restart_done", 32'(done),           32'd0);
        tick();
        tick();
        chk("t2_issue0_pc", 32'(bus.ex_pc), 32'd0);
        bus.ex_ready = 1'b1;
        tick();
        bus.ex_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_valid", 32'(bus.ex_valid),   32'd1);
            chk("t2_hold_instr", bus.ex_instr,        C_B);
            chk("t2_hold_pc",    32'(bus.ex_pc),      32'd1);
            chk("t2_hold_rd_en", 32'(bus.imem_rd_en), 32'd0);
            tick();
        end
        chk("t2_after_instr", bus.ex_instr, C_B);
`ifdef SEQ_STALL_CNT_EN
        chk("t2_stall", 32'(stall_cycles), 32'd5);
`endif
        bus.ex_ready = 1'b1;
        tick();
        chk("t2_next_addr", 32'(bus.imem_addr), 32'd2);

        // 3: jump during WAIT of pc 2
        tick();
        bus.jump_req    = 1'b1;
        bus.jump_target = 5'h11;
        tick();
        bus.jump_req = 1'b0;
        chk("t3_jump_en",    32'(bus.imem_rd_en), 32'd1);
        chk("t3_jump_addr",  32'(bus.imem_addr),  32'h11);
        chk("t3_jump_valid", 32'(bus.ex_valid),   32'd0);
        tick();
        tick();
        chk("t3_issue_pc",    32'(bus.ex_pc), 32'h11);
        chk("t3_issue_instr", bus.ex_instr,   C_E);

        // 4: jump coincident with handshake (non-HALT, then HALT)
        bus.jump_req    = 1'b1;
        bus.jump_target = 5'h03;
        tick();
        bus.jump_req = 1'b0;
        chk("t4_redirect_addr", 32'(bus.imem_addr), 32'd3);
        tick();
        tick();
        chk("t4_issue_pc",    32'(bus.ex_pc), 32'd3);
        chk("t4_issue_instr", bus.ex_instr,   C_HALT);
        bus.jump_req    = 1'b1;
        bus.jump_target = 5'h00;
        tick();
        bus.jump_req = 1'b0;
        chk("t4_halt_done",  32'(done),           32'd1);
        chk("t4_halt_rd_en", 32'(bus.imem_rd_en), 32'd0);
        chk("t4_halt_valid", 32'(bus.ex_valid),   32'd0);
        chk("t4_halt_busy",  32'(busy),           32'd0);

        // 5: jump in FETCH to pc 31, then wrap to 0
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SEQ_STALL_CNT_EN
        chk("t5_stall_clr", 32'(stall_cycles), 32'd0);
`endif
        bus.jump_req    = 1'b1;
        bus.jump_target = 5'h1F;
        tick();
        bus.jump_req = 1'b0;
        chk("t5_fetch_addr", 32'(bus.imem_addr), 32'h1F);
        tick();
        tick();
        chk("t5_issue_pc",    32'(bus.ex_pc), 32'h1F);
        chk("t5_issue_instr", bus.ex_instr,   C_D);
        tick();
        chk("t5_wrap_addr", 32'(bus.imem_addr),  32'd0);
        chk("t5_wrap_en",   32'(bus.imem_rd_en), 32'd1);

        // 6: start ignored while busy, reset in ISSUE, restart
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_issue_valid", 32'(bus.ex_valid), 32'd1);
        chk("t6_issue_instr", bus.ex_instr,      C_A);
        bus.ex_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("t6_rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
        chk("t6_rst_addr",  32'(bus.imem_addr),  32'd0);
        chk("t6_rst_valid", 32'(bus.ex_valid),   32'd0);
        chk("t6_rst_instr", bus.ex_instr,        32'd0);
        chk("t6_rst_pc",    32'(bus.ex_pc),      32'd0);
        chk("t6_rst_busy",  32'(busy),           32'd0);
        chk("t6_rst_done",  32'(done),           32'd0);
        reset = 1'b0;
        bus.jump_req    = 1'b1;
        bus.jump_target = 5'h05;
        tick();
        bus.jump_req = 1'b0;
        chk("t6_idle_jump_busy", 32'(busy),           32'd0);
        chk("t6_idle_jump_en",   32'(bus.imem_rd_en), 32'd0);
        bus.ex_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_restart_addr", 32'(bus.imem_addr), 32'd0);
        tick();
        tick();
        chk("t6_restart_pc",    32'(bus.ex_pc), 32'd0);
        chk("t6_restart_instr", bus.ex_instr,   C_A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
